// File: rtl/boot_loader.sv
// Boot sequencer: decodes a header/payload word stream into instruction or data BRAM
// writes, holding the CPU stalled until the last section has been written.
module boot_loader #(
    parameter int unsigned ADDR_W = 10,
    parameter logic [3:0]  MAGIC  = 4'hA
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       s_dat,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic              restart,
    output logic [ADDR_W-1:0] i_w_addr,
    output logic [31:0]       i_w_dat,
    output logic              i_w_enb,
    output logic [ADDR_W-1:0] d_w_addr,
    output logic [31:0]       d_w_dat,
    output logic              d_w_enb,
    output logic              d_bram_init_done,
    output logic              pc_stall,
    output logic              cpu_rd_enb,
    output logic              err
);

    localparam int unsigned CNT_W = 9;

    typedef enum logic [2:0] {
        S_HDR,
        S_LOAD,
        S_DRAIN,
        S_RUN,
        S_ERR
    } state_t;

    state_t            state, state_n;
    logic [ADDR_W-1:0] addr, addr_n;
    logic [CNT_W-1:0]  remaining, remaining_n;
    logic              tgt, tgt_n;
    logic              last, last_n;

    logic [ADDR_W-1:0] i_w_addr_n, d_w_addr_n;
    logic [31:0]       i_w_dat_n, d_w_dat_n;
    logic              i_w_enb_n, d_w_enb_n;
    logic              s_ready_n, pc_stall_n, cpu_rd_enb_n, init_done_n, err_n;
    logic              hs;

    // Header fields [17:16] and [15:8] carry no meaning for the loader.
    logic unused_hdr_bits;
    assign unused_hdr_bits = ^{s_dat[17:16], s_dat[15:8]};

    assign hs = s_valid && s_ready;

    // State, datapath and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state            <= S_HDR;
            addr             <= '0;
            remaining        <= '0;
            tgt              <= 1'b0;
            last             <= 1'b0;
            i_w_addr         <= '0;
            i_w_dat          <= '0;
            i_w_enb          <= 1'b0;
            d_w_addr         <= '0;
            d_w_dat          <= '0;
            d_w_enb          <= 1'b0;
            s_ready          <= 1'b1;
            pc_stall         <= 1'b1;
            cpu_rd_enb       <= 1'b0;
            d_bram_init_done <= 1'b0;
            err              <= 1'b0;
        end else begin
            state            <= state_n;
            addr             <= addr_n;
            remaining        <= remaining_n;
            tgt              <= tgt_n;
            last             <= last_n;
            i_w_addr         <= i_w_addr_n;
            i_w_dat          <= i_w_dat_n;
            i_w_enb          <= i_w_enb_n;
            d_w_addr         <= d_w_addr_n;
            d_w_dat          <= d_w_dat_n;
            d_w_enb          <= d_w_enb_n;
            s_ready          <= s_ready_n;
            pc_stall         <= pc_stall_n;
            cpu_rd_enb       <= cpu_rd_enb_n;
            d_bram_init_done <= init_done_n;
            err              <= err_n;
        end
    end

    // Next-state, datapath and output decode.
    always_comb begin
        state_n     = state;
        addr_n      = addr;
        remaining_n = remaining;
        tgt_n       = tgt;
        last_n      = last;
        i_w_addr_n  = i_w_addr;
        i_w_dat_n   = i_w_dat;
        i_w_enb_n   = 1'b0;
        d_w_addr_n  = d_w_addr;
        d_w_dat_n   = d_w_dat;
        d_w_enb_n   = 1'b0;

        case (state)
            S_HDR: begin
                if (hs) begin
                    if (s_dat[29:26] == MAGIC) begin
                        tgt_n       = s_dat[31];
                        last_n      = s_dat[30];
                        addr_n      = ADDR_W'({s_dat[25:18], 2'b00});
                        remaining_n = (s_dat[7:0] == 8'd0) ? CNT_W'(256) : CNT_W'(s_dat[7:0]);
                        state_n     = S_LOAD;
                    end else begin
                        state_n = S_ERR;
                    end
                end
            end
            S_LOAD: begin
                if (hs) begin
                    if (tgt) begin
                        d_w_addr_n = addr;
                        d_w_dat_n  = s_dat;
                        d_w_enb_n  = 1'b1;
                    end else begin
                        i_w_addr_n = addr;
                        i_w_dat_n  = s_dat;
                        i_w_enb_n  = 1'b1;
                    end
                    addr_n      = addr + ADDR_W'(4);
                    remaining_n = remaining - CNT_W'(1);
                    if (remaining == CNT_W'(1)) begin
                        state_n = last ? S_DRAIN : S_HDR;
                    end
                end
            end
            S_DRAIN: state_n = S_RUN;
            S_RUN: begin
                if (restart) begin
                    state_n = S_HDR;
                end
            end
            S_ERR:   state_n = S_ERR;
            default: state_n = S_ERR;
        endcase

        // Control outputs follow the state being entered so they are registered.
        s_ready_n    = (state_n == S_HDR) || (state_n == S_LOAD);
        pc_stall_n   = (state_n != S_RUN);
        cpu_rd_enb_n = (state_n == S_RUN);
        init_done_n  = (state_n == S_RUN);
        err_n        = (state_n == S_ERR);
    end

endmodule

// File: tb/tb_boot_loader.sv
// Randomized bench for boot_loader: a driver pushes expected BRAM writes into a
// scoreboard queue, a negedge monitor pops and compares each write the DUT issues.
module tb_boot_loader;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] s_dat;
    logic        s_valid;
    logic        s_ready;
    logic        restart;
    logic [9:0]  i_w_addr;
    logic [31:0] i_w_dat;
    logic        i_w_enb;
    logic [9:0]  d_w_addr;
    logic [31:0] d_w_dat;
    logic        d_w_enb;
    logic        d_bram_init_done;
    logic        pc_stall;
    logic        cpu_rd_enb;
    logic        err;

    typedef struct {
        bit          tgt;
        logic [9:0]  addr;
        logic [31:0] dat;
    } wr_t;

    wr_t exp_q[$];
    int  n_cmp = 0;
    int  n_bad = 0;

    boot_loader #(.ADDR_W(10), .MAGIC(4'hA)) dut (
        .clk(clk), .rst(rst),
        .s_dat(s_dat), .s_valid(s_valid), .s_ready(s_ready),
        .restart(restart),
        .i_w_addr(i_w_addr), .i_w_dat(i_w_dat), .i_w_enb(i_w_enb),
        .d_w_addr(d_w_addr), .d_w_dat(d_w_dat), .d_w_enb(d_w_enb),
        .d_bram_init_done(d_bram_init_done), .pc_stall(pc_stall),
        .cpu_rd_enb(cpu_rd_enb), .err(err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every write strobe must match the oldest expected write.
    always @(negedge clk) begin
        if (!rst && (i_w_enb || d_w_enb)) begin
            wr_t e;
            chk("wr_single_enb", 32'(i_w_enb && d_w_enb), 32'd0);
            chk("wr_init_done_low", 32'(d_bram_init_done), 32'd0);
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL wr_unexpected: i_enb=%0b d_enb=%0b with empty scoreboard at %0t",
                         i_w_enb, d_w_enb, $time);
            end else begin
                e = exp_q.pop_front();
                chk("wr_target", 32'(d_w_enb), 32'(e.tgt));
                chk("wr_addr", 32'(d_w_enb ? d_w_addr : i_w_addr), 32'(e.addr));
                chk("wr_data", d_w_enb ? d_w_dat : i_w_dat, e.dat);
            end
        end
    end

    // Present one word with optional idle gaps; returns at the negedge before its accept edge.
    task automatic put_word(input logic [31:0] w);
        int guard;
        while ($urandom_range(0, 3) == 0) begin
            @(negedge clk);
            s_valid = 1'b0;
            s_dat   = $urandom;
        end
        guard = 0;
        @(negedge clk);
        s_valid = 1'b1;
        s_dat   = w;
        while (!s_ready && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        if (!s_ready) begin
            n_cmp++;
            n_bad++;
            $display("FAIL accept_timeout: s_ready=0 expected 1 at %0t", $time);
        end
    endtask

    // Model: section writes land at aligned base + 4*i modulo 1024; count 0 means 256.
    task automatic send_section(input bit tgt, input bit last, input logic [9:0] base,
                                input logic [7:0] cnt);
        logic [31:0] hdr;
        logic [31:0] w;
        int          n;
        int          aligned;
        wr_t         e;
        n       = (cnt == 8'd0) ? 256 : int'(cnt);
        aligned = int'(base) & 32'h3FC;
        hdr     = {tgt, last, 4'hA, base[9:2], 2'($urandom), 8'($urandom), cnt};
        put_word(hdr);
        for (int i = 0; i < n; i++) begin
            w = $urandom;
            put_word(w);
            e.tgt  = tgt;
            e.addr = 10'((aligned + 4 * i) % 1024);
            e.dat  = w;
            exp_q.push_back(e);
        end
        if (last) begin
            @(negedge clk);
            s_valid = 1'b0;
            chk("drain_pc_stall", 32'(pc_stall), 32'd1);
            chk("drain_s_ready", 32'(s_ready), 32'd0);
            @(negedge clk);
            chk("run_pc_stall", 32'(pc_stall), 32'd0);
            chk("run_init_done", 32'(d_bram_init_done), 32'd1);
            chk("run_cpu_rd_enb", 32'(cpu_rd_enb), 32'd1);
            chk("run_s_ready", 32'(s_ready), 32'd0);
        end
    endtask

    // Multi-cycle restart request from RUN; must act once and return to header state.
    task automatic do_restart();
        @(negedge clk);
        restart = 1'b1;
        @(negedge clk);
        chk("restart_pc_stall", 32'(pc_stall), 32'd1);
        chk("restart_cpu_rd_enb", 32'(cpu_rd_enb), 32'd0);
        chk("restart_init_done", 32'(d_bram_init_done), 32'd0);
        chk("restart_s_ready", 32'(s_ready), 32'd1);
        @(negedge clk);
        restart = 1'b0;
        chk("restart_held_s_ready", 32'(s_ready), 32'd1);
    endtask

    task automatic chk_reset_vals();
        chk("rst_pc_stall", 32'(pc_stall), 32'd1);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_i_w_enb", 32'(i_w_enb), 32'd0);
        chk("rst_d_w_enb", 32'(d_w_enb), 32'd0);
        chk("rst_init_done", 32'(d_bram_init_done), 32'd0);
        chk("rst_cpu_rd_enb", 32'(cpu_rd_enb), 32'd0);
        chk("rst_i_w_addr", 32'(i_w_addr), 32'd0);
        chk("rst_d_w_dat", d_w_dat, 32'd0);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] w;
        int          nsec;
        wr_t         e;
        rst     = 1'b1;
        s_valid = 1'b0;
        s_dat   = '0;
        restart = 1'b0;
        repeat (2) @(negedge clk);
        chk_reset_vals();
        #1 rst = 1'b0;
        @(negedge clk);
        chk("post_rst_s_ready", 32'(s_ready), 32'd1);

        // Single data-target last section of 3 words.
        send_section(1'b1, 1'b1, 10'h000, 8'd3);
        do_restart();

        // Data section followed by instruction section, back to back.
        send_section(1'b1, 1'b0, 10'h000, 8'd4);
        chk("between_init_done", 32'(d_bram_init_done), 32'd0);
        send_section(1'b0, 1'b1, 10'h000, 8'd3);
        do_restart();

        // Address wrap at the top of the BRAM.
        send_section(1'b0, 1'b1, 10'h3F8, 8'd3);
        do_restart();

        // Count field zero means 256 words.
        send_section(1'($urandom), 1'b1, 10'($urandom), 8'd0);
        do_restart();

        // Random multi-section loads.
        for (int it = 0; it < 6; it++) begin
            nsec = $urandom_range(1, 3);
            for (int s = 0; s < nsec; s++) begin
                send_section(1'($urandom), (s == nsec - 1), 10'($urandom),
                             8'($urandom_range(1, 12)));
            end
            do_restart();
        end

        // Reset after 2 of 3 payload words; issued writes stay, rest discarded.
        put_word({1'b0, 1'b1, 4'hA, 8'h10, 2'b00, 8'h00, 8'd3});
        for (int i = 0; i < 2; i++) begin
            w = $urandom;
            put_word(w);
            e.tgt  = 1'b0;
            e.addr = 10'(32'h40 + 4 * i);
            e.dat  = w;
            exp_q.push_back(e);
        end
        @(negedge clk);
        s_valid = 1'b0;
        repeat (2) @(negedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        chk_reset_vals();
        chk("midload_sb_empty", 32'(exp_q.size()), 32'd0);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("midload_s_ready", 32'(s_ready), 32'd1);
        chk("midload_pc_stall", 32'(pc_stall), 32'd1);
        send_section(1'b1, 1'b1, 10'h100, 8'd5);
        do_restart();
        send_section(1'b0, 1'b1, 10'h020, 8'd2);

        // Bad magic: sticky error, stream and restart ignored until reset.
        do_restart();
        put_word({1'b1, 1'b1, 4'h8, 8'h00, 2'b00, 8'h00, 8'd1});
        @(negedge clk);
        s_valid = 1'b0;
        chk("err_set", 32'(err), 32'd1);
        chk("err_s_ready", 32'(s_ready), 32'd0);
        chk("err_pc_stall", 32'(pc_stall), 32'd1);
        for (int i = 0; i < 4; i++) begin
            s_valid = 1'b1;
            s_dat   = {1'b0, 1'b1, 4'hA, 18'h0, 8'd1};
            restart = 1'b1;
            @(negedge clk);
            chk("err_sticky", 32'(err), 32'd1);
            chk("err_no_ready", 32'(s_ready), 32'd0);
        end
        s_valid = 1'b0;
        restart = 1'b0;
        #1 rst = 1'b1;
        @(negedge clk);
        chk("err_cleared", 32'(err), 32'd0);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("err_recover_s_ready", 32'(s_ready), 32'd1);

        repeat (3) @(negedge clk);
        chk("final_sb_empty", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
